// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce and one-hot row/col key output.
// Optional auto-repeat of key_strobe while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV           = 16,
   parameter int DEBOUNCE_SCANS     = 4,
   parameter int REPEAT_DELAY_SCANS = 32,
   parameter int REPEAT_RATE_SCANS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_drive,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic       key_pressed,
   output logic       key_strobe
);

   // state      | meaning
   // S_IDLE     | no key held, waiting for a single-key scan
   // S_DEBOUNCE | candidate key seen, counting identical scans
   // S_PRESSED  | debounced key held, outputs valid
   // S_RELEASE  | candidate gone, counting empty scans before release
   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   // All scan counters share one width sized for the largest scan count in use.
   localparam int LP_MAX_A = (DEBOUNCE_SCANS > REPEAT_DELAY_SCANS) ? DEBOUNCE_SCANS : REPEAT_DELAY_SCANS;
   localparam int LP_MAX   = (LP_MAX_A > REPEAT_RATE_SCANS) ? LP_MAX_A : REPEAT_RATE_SCANS;
   localparam int LP_CW    = $clog2(LP_MAX + 1);
   localparam int LP_TW    = $clog2(SCAN_DIV);
   localparam logic [LP_TW-1:0] LP_TMAX = LP_TW'(SCAN_DIV - 1);
   localparam logic [LP_CW-1:0] LP_DEB  = LP_CW'(DEBOUNCE_SCANS);
   localparam logic [LP_CW-1:0] LP_ONE  = LP_CW'(1);

   logic [3:0]       r_col_s1, r_col_s2;
   logic [3:0]       r_row_drive;
   logic [LP_TW-1:0] r_timer;
   logic [1:0]       r_idx;
   logic [11:0]      r_snap;
   state_t           r_state, w_state_nxt;
   logic [15:0]      r_cand, w_cand_nxt;
   logic [LP_CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [3:0]       r_row, r_col, w_row_nxt, w_col_nxt;
   logic             r_key_pressed, r_key_strobe, w_strobe_nxt, w_enter_press;

   logic        w_sample, w_scan_end, w_empty, w_single, w_hit;
   logic [15:0] w_snap_full;

   assign w_sample    = (r_timer == LP_TMAX);
   assign w_scan_end  = w_sample && (r_idx == 2'd3);
   // Row 3 is being sampled on the scan-end cycle, so it comes straight from the synchroniser.
   assign w_snap_full = {r_col_s2, r_snap};
   assign w_empty     = (w_snap_full == 16'd0);
   assign w_single    = !w_empty && ((w_snap_full & (w_snap_full - 16'd1)) == 16'd0);
   assign w_hit       = |(w_snap_full & r_cand);
   assign w_cnt_inc   = r_cnt + LP_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col_s1    <= '0;
         r_col_s2    <= '0;
         r_row_drive <= 4'b0001;
         r_timer     <= '0;
         r_idx       <= '0;
         r_snap      <= '0;
      end else begin
         r_col_s1 <= col_in;
         r_col_s2 <= r_col_s1;
         if (w_sample) begin
            r_timer     <= '0;
            r_idx       <= r_idx + 2'd1;
            r_row_drive <= {r_row_drive[2:0], r_row_drive[3]};
            case (r_idx)
               2'd0:    r_snap[3:0]  <= r_col_s2;
               2'd1:    r_snap[7:4]  <= r_col_s2;
               2'd2:    r_snap[11:8] <= r_col_s2;
               default: ;
            endcase
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      if (w_scan_end) begin
         case (r_state)
            S_IDLE: begin
               if (w_single) begin
                  w_cand_nxt  = w_snap_full;
                  w_cnt_nxt   = LP_ONE;
                  w_state_nxt = (LP_ONE >= LP_DEB) ? S_PRESSED : S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (w_snap_full == r_cand) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc >= LP_DEB) w_state_nxt = S_PRESSED;
               end else if (w_single) begin
                  w_cand_nxt = w_snap_full;
                  w_cnt_nxt  = LP_ONE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_PRESSED: begin
               if (!w_hit) begin
                  w_state_nxt = S_RELEASE;
                  w_cnt_nxt   = LP_ONE;
               end
            end
            default: begin
               if (w_hit) begin
                  w_state_nxt = S_PRESSED;
               end else if (w_empty) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc >= LP_DEB) w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_row_nxt = '0;
      w_col_nxt = '0;
      for (int r = 0; r < 4; r++) begin
         w_row_nxt[r] = |w_cand_nxt[r*4 +: 4];
         w_col_nxt    = w_col_nxt | w_cand_nxt[r*4 +: 4];
      end
   end

   // A RELEASE->PRESSED bounce is the same press, so only IDLE/DEBOUNCE entries strobe.
   assign w_enter_press = w_scan_end && (w_state_nxt == S_PRESSED) &&
                          ((r_state == S_IDLE) || (r_state == S_DEBOUNCE));

`ifdef KEYPAD_REPEAT_EN
   localparam logic [LP_CW-1:0] LP_DLY  = LP_CW'(REPEAT_DELAY_SCANS);
   localparam logic [LP_CW-1:0] LP_RATE = LP_CW'(REPEAT_RATE_SCANS);

   logic [LP_CW-1:0] r_rep;
   logic             w_rep_fire;

   assign w_rep_fire   = w_scan_end && (r_state == S_PRESSED) &&
                         (w_state_nxt == S_PRESSED) && (r_rep == LP_ONE);
   assign w_strobe_nxt = w_enter_press || w_rep_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep <= '0;
      end else if (w_scan_end) begin
         if (w_state_nxt != S_PRESSED)  r_rep <= '0;
         else if (r_state != S_PRESSED) r_rep <= LP_DLY;
         else if (r_rep == LP_ONE)      r_rep <= LP_RATE;
         else                           r_rep <= r_rep - LP_ONE;
      end
   end
`else
   assign w_strobe_nxt = w_enter_press;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cand        <= '0;
         r_cnt         <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_key_pressed <= 1'b0;
         r_key_strobe  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cand       <= w_cand_nxt;
         r_cnt        <= w_cnt_nxt;
         r_key_strobe <= w_strobe_nxt;
         if (w_scan_end) begin
            if (w_state_nxt == S_PRESSED) begin
               r_row         <= w_row_nxt;
               r_col         <= w_col_nxt;
               r_key_pressed <= 1'b1;
            end else if (w_state_nxt == S_IDLE) begin
               r_row         <= '0;
               r_col         <= '0;
               r_key_pressed <= 1'b0;
            end
         end
      end
   end

   assign row_drive   = r_row_drive;
   assign row         = r_row;
   assign col         = r_col;
   assign key_pressed = r_key_pressed;
   assign key_strobe  = r_key_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected strobe/release events,
// a negedge monitor pops and compares them. Repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_scanner;
   localparam int SD   = 4;
   localparam int DEB  = 3;
   localparam int DLY  = 4;
   localparam int RATE = 2;
   localparam int SCAN = 4 * SD;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  row;
      logic [3:0]  col;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col_in;
   logic [3:0]  row_drive, row, col;
   logic        key_pressed, key_strobe;
   logic [15:0] tb_keys = '0;
   logic        kp_prev = 1'b0;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   ev_t         sq[$];
   ev_t         rq[$];

   keypad_scanner #(
      .SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB),
      .REPEAT_DELAY_SCANS(DLY), .REPEAT_RATE_SCANS(RATE)
   ) dut (
      .clk(clk), .rst(rst), .col_in(col_in), .row_drive(row_drive),
      .row(row), .col(col), .key_pressed(key_pressed), .key_strobe(key_strobe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keypad matrix model: a held key connects its row strobe to its column.
   always_comb begin
      col_in = '0;
      for (int r = 0; r < 4; r++)
         if (row_drive[r]) col_in = col_in | tb_keys[r*4 +: 4];
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (key_strobe) begin
         if (sq.size() == 0) begin
            chk("strobe_unexpected", key_strobe, 0);
         end else begin
            e = sq.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_row", row, e.row);
            chk("strobe_col", col, e.col);
            chk("strobe_key_pressed", key_pressed, 1);
         end
      end
      if (kp_prev && !key_pressed) begin
         if (rq.size() == 0) begin
            chk("release_unexpected", key_pressed, 1);
         end else begin
            e = rq.pop_front();
            chk("release_cycle", cyc, e.cyc);
            chk("release_row", row, e.row);
            chk("release_col", col, e.col);
         end
      end
      kp_prev = key_pressed;
   end

   // Advance to the first cycle of the next scan (row_drive back to 0001 after 1000).
   task automatic next_scan();
      int k;
      k = 0;
      while (row_drive != 4'b1000 && k < 4 * SCAN) begin @(posedge clk); #1; k++; end
      while (row_drive != 4'b0001 && k < 4 * SCAN) begin @(posedge clk); #1; k++; end
      if (k >= 4 * SCAN) chk("next_scan_timeout", k, 0);
   endtask

   task automatic press_hold(input logic [15:0] keys, input int held, input bit accept,
                             input logic [3:0] er, input logic [3:0] ec);
      ev_t e;
      int unsigned t0;
      t0 = cyc;
      tb_keys = keys;
      if (accept) begin
         e.row = er; e.col = ec;
         e.cyc = t0 + DEB * SCAN;
         sq.push_back(e);
`ifdef KEYPAD_REPEAT_EN
         for (int j = DLY; j <= held - DEB; j += RATE) begin
            e.cyc = t0 + (DEB + j) * SCAN;
            sq.push_back(e);
         end
`endif
      end
      for (int s = 0; s < held; s++) begin
         next_scan();
         if (accept && s == DEB) begin
            chk("hold_key_pressed", key_pressed, 1);
            chk("hold_row", row, er);
            chk("hold_col", col, ec);
         end
      end
      tb_keys = '0;
      if (accept) begin
         e.row = '0; e.col = '0;
         e.cyc = cyc + DEB * SCAN;
         rq.push_back(e);
      end
      repeat (DEB + 2) next_scan();
      if (!accept) chk("no_press_key_pressed", key_pressed, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ev_t e;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_row_drive", row_drive, 4'b0001);
      chk("reset_row", row, 0);
      chk("reset_col", col, 0);
      chk("reset_key_pressed", key_pressed, 0);
      chk("reset_key_strobe", key_strobe, 0);
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("row_drive_rotate", row_drive, 4'b0001 << (k / 4));
         @(posedge clk); #1;
      end

      // clean press row1/col2
      press_hold(16'h0040, 10, 1'b1, 4'b0010, 4'b0100);
      // bounce: only two scans
      press_hold(16'h0040, 2, 1'b0, 4'b0000, 4'b0000);

      // one-scan dropout on row3/col0 must not strobe again or release
      tb_keys = 16'h1000;
      e.row = 4'b1000; e.col = 4'b0001; e.cyc = cyc + DEB * SCAN;
      sq.push_back(e);
      repeat (5) next_scan();
      tb_keys = '0;
      next_scan();
      chk("dropout_key_pressed", key_pressed, 1);
      tb_keys = 16'h1000;
      repeat (4) next_scan();
      tb_keys = '0;
      e.row = '0; e.col = '0; e.cyc = cyc + DEB * SCAN;
      rq.push_back(e);
      repeat (DEB + 2) next_scan();

      // ghost: row0/col0 and row2/col3 together
      press_hold(16'h0801, 5, 1'b0, 4'b0000, 4'b0000);

      // reset during debounce
      tb_keys = 16'h0004;
      repeat (2) next_scan();
      rst = 1'b1;
      tb_keys = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_row_drive", row_drive, 4'b0001);
      chk("midrst_key_pressed", key_pressed, 0);
      chk("midrst_key_strobe", key_strobe, 0);
      rst = 1'b0;
      repeat (DEB + 2) next_scan();
      chk("midrst_no_press", key_pressed, 0);

      // long hold row2/col1 (auto-repeat window when enabled)
      press_hold(16'h0200, 12, 1'b1, 4'b0100, 4'b0010);

      repeat (4) next_scan();
      chk("strobes_outstanding", sq.size(), 0);
      chk("releases_outstanding", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
